piradip_axis_packer: RTL and testbench

PIRADIP_AXIS_PACKER -- requirements
Module: piradip_axis_packer

---
 rtl/piradip_axis_packer.sv | 110 +++++++++++
 tb/tb_piradip_axis_packer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piradip_axis_packer.sv
// AXI-Stream width packer: gathers RATIO narrow input beats into one wide output word, lane 0 in LSBs.
// Optional byte mask output m_axis_tkeep is built when PIRADIP_AXIS_PACKER_TKEEP_EN is defined.
module piradip_axis_packer #(
  parameter int unsigned IN_WIDTH = 32,
  parameter int unsigned RATIO    = 4,
  localparam int unsigned OUT_WIDTH  = IN_WIDTH * RATIO,
  localparam int unsigned KEEP_WIDTH = OUT_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [IN_WIDTH-1:0]   s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [OUT_WIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
`ifdef PIRADIP_AXIS_PACKER_TKEEP_EN
  ,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep
`endif
);

  localparam int unsigned CNT_W      = $clog2(RATIO);
  localparam int unsigned ACC_WIDTH  = IN_WIDTH * (RATIO - 1);
  localparam int unsigned LANE_BYTES = IN_WIDTH / 8;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 accept;
  logic                 complete;
`ifdef PIRADIP_AXIS_PACKER_TKEEP_EN
  logic [KEEP_WIDTH-1:0] keep_q, keep_d;
`endif

  assign s_axis_tready = ~valid_q | m_axis_tready;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign complete      = accept & (s_axis_tlast | (cnt_q == CNT_W'(RATIO - 1)));

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
`ifdef PIRADIP_AXIS_PACKER_TKEEP_EN
    keep_d  = keep_q;
`endif

    if (valid_q && m_axis_tready) begin
      valid_d = 1'b0;
    end

    if (complete) begin
      // Accumulator lanes at or above the counter are always zero (cleared per word),
      // so OR-ing in the shifted final beat yields zeros in the unused upper lanes.
      data_d  = OUT_WIDTH'(acc_q) | (OUT_WIDTH'(s_axis_tdata) << (cnt_q * IN_WIDTH));
      valid_d = 1'b1;
      last_d  = s_axis_tlast;
      cnt_d   = '0;
      acc_d   = '0;
`ifdef PIRADIP_AXIS_PACKER_TKEEP_EN
      for (int unsigned i = 0; i < RATIO; i++) begin
        keep_d[i*LANE_BYTES +: LANE_BYTES] = {LANE_BYTES{CNT_W'(i) <= cnt_q}};
      end
`endif
    end else if (accept) begin
      for (int unsigned i = 0; i < RATIO - 1; i++) begin
        if (CNT_W'(i) == cnt_q) begin
          acc_d[i*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
        end
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef PIRADIP_AXIS_PACKER_TKEEP_EN
      keep_q  <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
`ifdef PIRADIP_AXIS_PACKER_TKEEP_EN
      keep_q  <= keep_d;
`endif
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;
`ifdef PIRADIP_AXIS_PACKER_TKEEP_EN
  assign m_axis_tkeep  = keep_q;
`endif

endmodule

// File: tb/tb_piradip_axis_packer.sv
// Self-checking bench for piradip_axis_packer (IN_WIDTH=32, RATIO=4); tkeep checks follow
// PIRADIP_AXIS_PACKER_TKEEP_EN.
module tb_piradip_axis_packer;

  localparam int unsigned IW = 32;
  localparam int unsigned R  = 4;
  localparam int unsigned OW = IW * R;
  localparam int unsigned KW = OW / 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [IW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [OW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
`ifdef PIRADIP_AXIS_PACKER_TKEEP_EN
  logic [KW-1:0] m_axis_tkeep;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 aclk = ~aclk;

  piradip_axis_packer #(.IN_WIDTH(IW), .RATIO(R)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
`ifdef PIRADIP_AXIS_PACKER_TKEEP_EN
    ,
    .m_axis_tkeep  (m_axis_tkeep)
`endif
  );

  typedef struct {
    logic [IW-1:0] d;
    logic          v;
    logic          l;
    logic          mr;
    logic          exp_sr;
    logic          exp_mv;
    logic          exp_ml;
    logic [OW-1:0] exp_md;
    logic [KW-1:0] exp_mk;
  } vec_t;

  function automatic vec_t mk(input logic [IW-1:0] d, input logic v, input logic l, input logic mr,
                              input logic sr, input logic mv, input logic ml,
                              input logic [OW-1:0] md, input logic [KW-1:0] mk_keep);
    vec_t r;
    r.d = d; r.v = v; r.l = l; r.mr = mr;
    r.exp_sr = sr; r.exp_mv = mv; r.exp_ml = ml; r.exp_md = md; r.exp_mk = mk_keep;
    return r;
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_keep(input string name, input logic [KW-1:0] exp);
`ifdef PIRADIP_AXIS_PACKER_TKEEP_EN
    check(name, OW'(m_axis_tkeep), OW'(exp));
`else
    if (exp === 'x) $display("keep %s unused", name);
`endif
  endtask

  task automatic drive(input logic [IW-1:0] d, input logic v, input logic l, input logic mr);
    s_axis_tdata  = d;
    s_axis_tvalid = v;
    s_axis_tlast  = l;
    m_axis_tready = mr;
  endtask

  // One cycle: drive at negedge, return #1 after the following posedge.
  task automatic beat(input logic [IW-1:0] d, input logic v, input logic l, input logic mr);
    @(negedge aclk);
    drive(d, v, l, mr);
    @(posedge aclk);
    #1;
  endtask

  // Streams 64 beats with random handshakes and compares against a packing model.
  task automatic run_stream(input string tag, input int vpct, input int rlow_pct, input int lpct,
                            output int stalls, output int accept_cycles);
    logic [IW-1:0] bd[64];
    logic          bl[64];
    logic [OW-1:0] q_d[$];
    logic          q_l[$];
    logic [KW-1:0] q_k[$];
    logic [OW-1:0] word;
    int            lanes;
    int            k;
    int            cyc;
    logic          v;
    logic          mr;

    for (int j = 0; j < 64; j++) begin
      bd[j] = $urandom;
      bl[j] = ($urandom_range(0, 99) < lpct);
    end
    if (lpct > 0) bl[63] = 1'b1;

    word = '0;
    lanes = 0;
    for (int j = 0; j < 64; j++) begin
      word = word | ({{(OW-IW){1'b0}}, bd[j]} << (IW * lanes));
      lanes++;
      if (lanes == R || bl[j]) begin
        q_d.push_back(word);
        q_l.push_back(bl[j]);
        q_k.push_back(KW'((33'h1 << (8 * (IW / 8) * lanes / 8 * 1)) - 1));
        word = '0;
        lanes = 0;
      end
    end

    k = 0; cyc = 0; stalls = 0; accept_cycles = -1;
    while ((k < 64 || q_d.size() > 0) && cyc < 3000) begin
      @(negedge aclk);
      v  = (k < 64) && ($urandom_range(0, 99) < vpct);
      mr = ($urandom_range(0, 99) >= rlow_pct);
      drive(v ? bd[k] : IW'($urandom), v, v ? bl[k] : 1'($urandom), mr);
      #1;
      if (m_axis_tvalid && mr) begin
        if (q_d.size() == 0) begin
          vecs++; errs++;
          $display("FAIL %s_extra_word: got %h, expected no word", tag, m_axis_tdata);
        end else begin
          check({tag, "_data"}, m_axis_tdata, q_d.pop_front());
          check({tag, "_last"}, OW'(m_axis_tlast), OW'(q_l.pop_front()));
          check_keep({tag, "_keep"}, q_k.pop_front());
        end
      end
      if (v && !s_axis_tready) stalls++;
      if (v && s_axis_tready) begin
        k++;
        if (k == 64) accept_cycles = cyc + 1;
      end
      @(posedge aclk);
      cyc++;
    end
    check({tag, "_drained"}, OW'(64 - k + q_d.size()), OW'(0));
    @(negedge aclk);
    drive('0, 1'b0, 1'b0, 1'b1);
  endtask

  vec_t tbl[11];
  int   stalls;
  int   acc_cyc;
  logic [OW-1:0] held;

  initial begin
    tbl[0]  = mk(32'h11, 1, 0, 1, 1, 0, 0, '0, '0);
    tbl[1]  = mk(32'h22, 1, 0, 1, 1, 0, 0, '0, '0);
    tbl[2]  = mk(32'h33, 1, 0, 1, 1, 0, 0, '0, '0);
    tbl[3]  = mk(32'h44, 1, 0, 1, 1, 1, 0, 128'h00000044_00000033_00000022_00000011, 16'hFFFF);
    tbl[4]  = mk(32'h0A, 1, 0, 1, 1, 0, 0, '0, '0);
    tbl[5]  = mk(32'h0B, 1, 1, 1, 1, 1, 1, 128'h0000000B_0000000A, 16'h00FF);
    tbl[6]  = mk(32'hDEAD, 0, 1, 1, 1, 0, 0, '0, '0);
    tbl[7]  = mk(32'hBEEF, 0, 0, 0, 1, 0, 0, '0, '0);
    tbl[8]  = mk(32'hC5, 1, 1, 1, 1, 1, 1, 128'hC5, 16'h000F);
    tbl[9]  = mk(32'h77, 1, 0, 0, 0, 1, 1, 128'hC5, 16'h000F);
    tbl[10] = mk(32'h0, 0, 0, 1, 1, 0, 0, '0, '0);

    // Reset state
    #2;
    check("rst_sready", OW'(s_axis_tready), OW'(1));
    check("rst_mvalid", OW'(m_axis_tvalid), OW'(0));
    check("rst_mdata", m_axis_tdata, '0);
    check("rst_mlast", OW'(m_axis_tlast), OW'(0));
    check_keep("rst_keep", '0);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;

    // Table-driven basic packing, partial words, one-lane word, backpressure hold
    for (int i = 0; i < 11; i++) begin
      @(negedge aclk);
      drive(tbl[i].d, tbl[i].v, tbl[i].l, tbl[i].mr);
      #1;
      check($sformatf("tbl%0d_sready", i), OW'(s_axis_tready), OW'(tbl[i].exp_sr));
      @(posedge aclk);
      #1;
      check($sformatf("tbl%0d_mvalid", i), OW'(m_axis_tvalid), OW'(tbl[i].exp_mv));
      if (tbl[i].exp_mv) begin
        check($sformatf("tbl%0d_mdata", i), m_axis_tdata, tbl[i].exp_md);
        check($sformatf("tbl%0d_mlast", i), OW'(m_axis_tlast), OW'(tbl[i].exp_ml));
        check_keep($sformatf("tbl%0d_keep", i), tbl[i].exp_mk);
      end
    end

    // Ten cycles of downstream backpressure with a pending word
    for (int i = 0; i < 4; i++) beat(IW'(32'h100 + i), 1, 0, 1);
    held = 128'h00000103_00000102_00000101_00000100;
    check("bp_word_valid", OW'(m_axis_tvalid), OW'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      drive(32'h200, 1, 0, 0);
      #1;
      check("bp_sready_low", OW'(s_axis_tready), OW'(0));
      @(posedge aclk);
      #1;
      check("bp_mvalid_hold", OW'(m_axis_tvalid), OW'(1));
      check("bp_mdata_hold", m_axis_tdata, held);
    end
    for (int i = 0; i < 4; i++) beat(IW'(32'h200 + i), 1, 0, 1);
    check("bp_next_valid", OW'(m_axis_tvalid), OW'(1));
    check("bp_next_data", m_axis_tdata, 128'h00000203_00000202_00000201_00000200);
    beat('0, 0, 0, 1);

    // Reset mid-word discards the partial fill
    beat(32'h55, 1, 0, 1);
    beat(32'h66, 1, 0, 1);
    @(negedge aclk);
    drive('0, 0, 0, 1);
    aresetn = 1'b0;
    #1;
    check("mrst_mvalid", OW'(m_axis_tvalid), OW'(0));
    check("mrst_sready", OW'(s_axis_tready), OW'(1));
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      beat(IW'(i), 1, 0, 1);
      check("mrst_no_word", OW'(m_axis_tvalid), OW'(0));
    end
    beat(32'h4, 1, 0, 1);
    check("mrst_valid", OW'(m_axis_tvalid), OW'(1));
    check("mrst_data", m_axis_tdata, 128'h00000004_00000003_00000002_00000001);
    check("mrst_last", OW'(m_axis_tlast), OW'(0));
    check_keep("mrst_keep", 16'hFFFF);
    beat('0, 0, 0, 1);

    // Randomized traffic against the packing model
    run_stream("rand", 70, 30, 15, stalls, acc_cyc);
    run_stream("tput", 100, 0, 0, stalls, acc_cyc);
    check("tput_stalls", OW'(stalls), OW'(0));
    check("tput_cycles", OW'(acc_cyc), OW'(64));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
